// File: rtl/sobel_window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen_pkg
//  Description : Shared Sobel types and constants: pixel width, window size
//                and the 3x3 window structure fed to the Sobel core.
//  Revision    : 1.0  initial release
// ============================================================================
package sobel_window_gen_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int WINDOW_SIZE = 3;

  // One window row; pix0 is the leftmost (oldest) column.
  typedef struct packed {
    logic [PIXEL_WIDTH-1:0] pix0;
    logic [PIXEL_WIDTH-1:0] pix1;
    logic [PIXEL_WIDTH-1:0] pix2;
  } sobel_vector;

  // Full window; vector0 is the top (oldest) line, vector2 the current line.
  typedef struct packed {
    sobel_vector vector0;
    sobel_vector vector1;
    sobel_vector vector2;
  } sobel_matrix;

endpackage
`default_nettype wire

// File: rtl/sobel_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_line_buffer
//  Description : Enable-gated shift register; q_o is the sample written
//                exactly DEPTH enabled cycles earlier. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] taps_q [DEPTH];
  logic [WIDTH-1:0] taps_d [DEPTH];

  // Next tap contents: shift by one position on every enabled cycle.
  always_comb begin
    taps_d = taps_q;
    if (en_i) begin
      taps_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  // Tap storage; no reset because stale data is masked by the window logic.
  always_ff @(posedge clk_i) begin
    taps_q <= taps_d;
  end

  assign q_o = taps_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_gen
//  Description : Raster pixel stream to 3x3 interior windows for the Sobel
//                core. Two line buffers supply the previous two lines; the
//                output is a one-deep register that back-pressures the input.
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sof_i,
  input  logic [PIXEL_WIDTH-1:0] pix_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  output sobel_matrix            matrix_pixels_o,
  output logic                   win_valid_o,
  input  logic                   win_ready_i,
  output logic                   frame_done_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]       col_q, col_d, eff_col;
  logic [ROW_W-1:0]       row_q, row_d, eff_row;
  sobel_matrix            matrix_q, matrix_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   acc;
  logic [PIXEL_WIDTH-1:0] lb0_out, lb1_out;

  assign pix_ready_o = !win_valid_q || win_ready_i;
  assign acc         = pix_valid_i && pix_ready_o;

  // A start-of-frame pixel is always position (0,0), whatever the counters say.
  assign eff_col = sof_i ? '0 : col_q;
  assign eff_row = sof_i ? '0 : row_q;

  // lb1 holds the previous line, lb0 the line before that.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb1 (
    .clk_i (clk_i),
    .en_i  (acc),
    .d_i   (pix_i),
    .q_o   (lb1_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_WIDTH)) u_lb0 (
    .clk_i (clk_i),
    .en_i  (acc),
    .d_i   (lb1_out),
    .q_o   (lb0_out)
  );

  // Raster counters, window shift and output-valid handshake.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    matrix_d     = matrix_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;

    if (win_valid_q && win_ready_i) begin
      win_valid_d = 1'b0;
    end

    if (acc) begin
      if (eff_col == COL_LAST) begin
        col_d = '0;
        if (eff_row == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = eff_row + ROW_W'(1);
        end
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end

      matrix_d.vector0.pix0 = matrix_q.vector0.pix1;
      matrix_d.vector0.pix1 = matrix_q.vector0.pix2;
      matrix_d.vector0.pix2 = lb0_out;
      matrix_d.vector1.pix0 = matrix_q.vector1.pix1;
      matrix_d.vector1.pix1 = matrix_q.vector1.pix2;
      matrix_d.vector1.pix2 = lb1_out;
      matrix_d.vector2.pix0 = matrix_q.vector2.pix1;
      matrix_d.vector2.pix1 = matrix_q.vector2.pix2;
      matrix_d.vector2.pix2 = pix_i;

      // Only positions with two full lines above and two columns to the
      // left form an interior window, so no window straddles a line wrap.
      if (eff_row >= ROW_W'(2) && eff_col >= COL_W'(2)) begin
        win_valid_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q        <= '0;
      row_q        <= '0;
      matrix_q     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      matrix_q     <= matrix_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign matrix_pixels_o = matrix_q;
  assign win_valid_o     = win_valid_q;
  assign frame_done_o    = frame_done_q;

endmodule
`default_nettype wire
